// File: rtl/visor_bp_if.sv
// Visor breakpoint unit bus: visor configuration, target fetch path and
// target control outputs grouped so the unit has a single port bundle.
interface visor_bp_if;
   logic [15:0] bp_wr_data;
   logic [1:0]  bp_wr_sel;
   logic        bp_we;
   logic [2:0]  bus_ctrl;
   logic [2:0]  tg_force;
   logic        tg_fetch;
   logic [15:0] tg_code_addr;
   logic [15:0] tg_rom_data;
   logic [15:0] tg_code_in;
   logic [15:0] tg_code_out;
   logic        tg_reset_out;
   logic        tg_hold;
   logic        tg_load_exr;
   logic        tg_exec;
   logic [3:0]  bp_status;
   logic [15:0] exr_shadow;

   modport master (
      output bp_wr_data, bp_wr_sel, bp_we, bus_ctrl, tg_force,
             tg_fetch, tg_code_addr, tg_rom_data, tg_code_in,
      input  tg_code_out, tg_reset_out, tg_hold, tg_load_exr, tg_exec,
             bp_status, exr_shadow
   );

   modport slave (
      input  bp_wr_data, bp_wr_sel, bp_we, bus_ctrl, tg_force,
             tg_fetch, tg_code_addr, tg_rom_data, tg_code_in,
      output tg_code_out, tg_reset_out, tg_hold, tg_load_exr, tg_exec,
             bp_status, exr_shadow
   );
endinterface

// File: rtl/visor_bp_unit.sv
// Visor breakpoint unit: four address breakpoint slots watching the target
// fetch stream, stalling the target on a hit and capturing the ROM word
// that would have executed. Also muxes the code bus and generates single
// cycle load/execute pulses from the visor force levels.
module visor_bp_unit #(
   parameter logic [15:0] BP_DISABLE = 16'hFFFF,
   parameter int          NUM_BP     = 4
) (
   input logic       clk,
   input logic       reset,
   visor_bp_if.slave bus
);

   logic [15:0]       bp_addr [NUM_BP];
   logic [NUM_BP-1:0] pass;
   logic [NUM_BP-1:0] status;
   logic [NUM_BP-1:0] match;
   logic [NUM_BP-1:0] wr_hit;
   logic [NUM_BP-1:0] hit_set;
   logic [15:0]       exr_q;
   logic              rst_out_q;
   logic              load_q;
   logic              exec_q;
   logic              armed;
   logic [2:1]        force_hist;
   logic              unused_bits;

   assign unused_bits = bus.bus_ctrl[0];

   // Slot compare; a write to a slot in the same cycle masks its hit.
   always_comb begin
      wr_hit = '0;
      match  = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         wr_hit[i] = bus.bp_we && (bus.bp_wr_sel == 2'(i));
         match[i]  = bus.tg_fetch && (bp_addr[i] == bus.tg_code_addr) &&
                     (bp_addr[i] != BP_DISABLE) && !pass[i] && !rst_out_q;
      end
      hit_set = match & ~wr_hit;
   end

   assign bus.tg_code_out  = bus.bus_ctrl[2] ? bus.tg_code_in : bus.tg_rom_data;
   // Hold goes high in the match cycle itself so the breakpoint word never executes.
   assign bus.tg_hold      = (|status) | bus.tg_force[0] | (|hit_set);
   assign bus.tg_reset_out = rst_out_q;
   assign bus.tg_load_exr  = load_q;
   assign bus.tg_exec      = exec_q;
   assign bus.bp_status    = status;
   assign bus.exr_shadow   = exr_q;

   // Slot registers: address, hit flag and pass-once flag per slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= BP_DISABLE;
         pass   <= '0;
         status <= '0;
      end else begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (wr_hit[i]) begin
               bp_addr[i] <= bus.bp_wr_data;
               status[i]  <= 1'b0;
               // Re-arming a slot that just hit lets the target step past it once.
               pass[i]    <= status[i];
            end else begin
               if (rst_out_q)       status[i] <= 1'b0;
               else if (hit_set[i]) status[i] <= 1'b1;
               if (bus.tg_fetch && (bus.tg_code_addr != bp_addr[i])) pass[i] <= 1'b0;
            end
         end
      end
   end

   // Shadow of the ROM word at the first hit; frozen while any slot is hit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          exr_q <= '0;
      else if ((|hit_set) && !(|status))  exr_q <= bus.tg_rom_data;
   end

   // Target reset follower and rising-edge pulses from the force levels.
   // armed suppresses pulses on the first edge after reset so levels that
   // were already high during reset do not fire.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_out_q  <= 1'b1;
         load_q     <= 1'b0;
         exec_q     <= 1'b0;
         armed      <= 1'b0;
         force_hist <= '0;
      end else begin
         rst_out_q  <= bus.bus_ctrl[1];
         armed      <= 1'b1;
         force_hist <= bus.tg_force[2:1];
         load_q     <= armed && bus.tg_force[1] && !force_hist[1];
         exec_q     <= armed && bus.tg_force[2] && !force_hist[2];
      end
   end

endmodule

// File: tb/tb_visor_bp_unit.sv
// Scoreboard bench for visor_bp_unit: expectations are queued when stimulus
// is applied and compared when the corresponding output is due, either
// combinationally (q_now) or after the next clock edge (q_post).
module tb_visor_bp_unit;

   localparam int S_STATUS = 0;
   localparam int S_EXR    = 1;
   localparam int S_HOLD   = 2;
   localparam int S_LOAD   = 3;
   localparam int S_EXEC   = 4;
   localparam int S_CODE   = 5;
   localparam int S_RST    = 6;

   typedef struct {
      string       tag;
      int          sel;
      logic [15:0] val;
   } exp_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   exp_t q_now[$];
   exp_t q_post[$];

   visor_bp_if bif ();

   visor_bp_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] obs_of(input int sel);
      case (sel)
         S_STATUS: obs_of = {12'h0, bif.bp_status};
         S_EXR:    obs_of = bif.exr_shadow;
         S_HOLD:   obs_of = {15'h0, bif.tg_hold};
         S_LOAD:   obs_of = {15'h0, bif.tg_load_exr};
         S_EXEC:   obs_of = {15'h0, bif.tg_exec};
         S_CODE:   obs_of = bif.tg_code_out;
         default:  obs_of = {15'h0, bif.tg_reset_out};
      endcase
   endfunction

   task automatic exp_now(input string tag, input int sel, input logic [15:0] v);
      exp_t e;
      e.tag = tag; e.sel = sel; e.val = v;
      q_now.push_back(e);
   endtask

   task automatic exp_post(input string tag, input int sel, input logic [15:0] v);
      exp_t e;
      e.tag = tag; e.sel = sel; e.val = v;
      q_post.push_back(e);
   endtask

   task automatic settle();
      exp_t e;
      #1;
      while (q_now.size() > 0) begin
         e = q_now.pop_front();
         check_val(e.tag, obs_of(e.sel), e.val);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (q_post.size() > 0) begin
         e = q_post.pop_front();
         check_val(e.tag, obs_of(e.sel), e.val);
      end
   endtask

   task automatic wr_bp(input logic [1:0] sel, input logic [15:0] data);
      bif.bp_we      = 1'b1;
      bif.bp_wr_sel  = sel;
      bif.bp_wr_data = data;
      tick();
      bif.bp_we      = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] addr, input logic [15:0] rom);
      bif.tg_fetch     = 1'b1;
      bif.tg_code_addr = addr;
      bif.tg_rom_data  = rom;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bif.bp_wr_data   = '0;
      bif.bp_wr_sel    = '0;
      bif.bp_we        = 1'b0;
      bif.bus_ctrl     = 3'b000;
      bif.tg_force     = 3'b110;
      bif.tg_fetch     = 1'b0;
      bif.tg_code_addr = '0;
      bif.tg_rom_data  = '0;
      bif.tg_code_in   = '0;

      // reset values, with force levels already high during reset
      #3;
      exp_now("rst_status", S_STATUS, 16'h0);
      exp_now("rst_exr",    S_EXR,    16'h0);
      exp_now("rst_tgrst",  S_RST,    16'h1);
      exp_now("rst_load",   S_LOAD,   16'h0);
      exp_now("rst_exec",   S_EXEC,   16'h0);
      settle();
      #8 reset = 1'b0;
      exp_post("rel_load",  S_LOAD, 16'h0);
      exp_post("rel_exec",  S_EXEC, 16'h0);
      exp_post("rel_tgrst", S_RST,  16'h0);
      tick();
      exp_post("stale_load", S_LOAD, 16'h0);
      exp_post("stale_exec", S_EXEC, 16'h0);
      tick();
      bif.tg_force = 3'b000;
      tick();

      // basic hit on slot 0
      wr_bp(2'd0, 16'h0015);
      fetch(16'h0014, 16'h1111);
      exp_now("miss_hold", S_HOLD, 16'h0);
      settle();
      exp_post("miss_status", S_STATUS, 16'h0);
      tick();
      fetch(16'h0015, 16'hABCD);
      exp_now("hit_hold_comb", S_HOLD, 16'h1);
      settle();
      exp_post("hit_status", S_STATUS, 16'h1);
      exp_post("hit_exr",    S_EXR,    16'hABCD);
      tick();
      bif.tg_fetch = 1'b0;
      exp_now("hit_hold_reg", S_HOLD, 16'h1);
      settle();

      // rewrite while hit: pass once, then re-hit after a different fetch
      exp_post("rewr_status", S_STATUS, 16'h0);
      wr_bp(2'd0, 16'h0015);
      fetch(16'h0015, 16'h2222);
      exp_now("pass_hold", S_HOLD, 16'h0);
      settle();
      exp_post("pass_status", S_STATUS, 16'h0);
      exp_post("pass_exr",    S_EXR,    16'hABCD);
      tick();
      fetch(16'h0016, 16'h2223);
      exp_post("other_status", S_STATUS, 16'h0);
      tick();
      fetch(16'h0015, 16'h3333);
      exp_now("rehit_hold", S_HOLD, 16'h1);
      settle();
      exp_post("rehit_status", S_STATUS, 16'h1);
      exp_post("rehit_exr",    S_EXR,    16'h3333);
      tick();
      fetch(16'h0015, 16'h4444);
      exp_post("frozen_exr", S_EXR, 16'h3333);
      tick();
      bif.tg_fetch = 1'b0;
      exp_post("dis0_status", S_STATUS, 16'h0);
      wr_bp(2'd0, 16'hFFFF);

      // force edge pulses
      bif.tg_force = 3'b011;
      exp_now("dbg_hold", S_HOLD, 16'h1);
      settle();
      exp_post("load_p1", S_LOAD, 16'h1);
      exp_post("exec_p1", S_EXEC, 16'h0);
      tick();
      exp_post("load_p2", S_LOAD, 16'h0);
      tick();
      exp_post("load_p3", S_LOAD, 16'h0);
      tick();
      bif.tg_force = 3'b101;
      exp_post("exec_p4", S_EXEC, 16'h1);
      exp_post("load_p4", S_LOAD, 16'h0);
      tick();
      exp_post("exec_p5", S_EXEC, 16'h0);
      tick();
      bif.tg_force = 3'b000;
      tick();

      // code bus divert
      bif.bus_ctrl    = 3'b100;
      bif.tg_code_in  = 16'h3C07;
      bif.tg_rom_data = 16'h1234;
      exp_now("code_divert", S_CODE, 16'h3C07);
      settle();
      bif.bus_ctrl = 3'b000;
      exp_now("code_rom", S_CODE, 16'h1234);
      settle();

      // target reset masks hits but keeps addresses
      wr_bp(2'd1, 16'h0040);
      bif.bus_ctrl = 3'b010;
      exp_post("tgrst_on", S_RST, 16'h1);
      tick();
      fetch(16'h0040, 16'h5550);
      exp_now("tgrst_hold", S_HOLD, 16'h0);
      settle();
      exp_post("tgrst_status", S_STATUS, 16'h0);
      tick();
      bif.tg_fetch = 1'b0;
      bif.bus_ctrl = 3'b000;
      exp_post("tgrst_off", S_RST, 16'h0);
      tick();
      fetch(16'h0040, 16'h5555);
      exp_now("slot1_hold", S_HOLD, 16'h1);
      settle();
      exp_post("slot1_status", S_STATUS, 16'h2);
      exp_post("slot1_exr",    S_EXR,    16'h5555);
      tick();
      bif.tg_fetch = 1'b0;
      wr_bp(2'd1, 16'hFFFF);
      wr_bp(2'd1, 16'h0050);

      // write wins over a simultaneous match on the same slot
      fetch(16'h0050, 16'h7777);
      exp_post("wrwin_status", S_STATUS, 16'h0);
      exp_post("wrwin_exr",    S_EXR,    16'h5555);
      wr_bp(2'd1, 16'h0050);
      bif.tg_fetch = 1'b0;
      wr_bp(2'd1, 16'hFFFF);

      // two slots on one address, then reset in the middle of the hold
      wr_bp(2'd0, 16'h0020);
      wr_bp(2'd2, 16'h0020);
      fetch(16'h0020, 16'h9999);
      exp_post("dual_status", S_STATUS, 16'h5);
      exp_post("dual_exr",    S_EXR,    16'h9999);
      tick();
      bif.tg_fetch = 1'b0;
      reset = 1'b1;
      exp_now("mid_status", S_STATUS, 16'h0);
      exp_now("mid_exr",    S_EXR,    16'h0);
      exp_now("mid_hold",   S_HOLD,   16'h0);
      exp_now("mid_tgrst",  S_RST,    16'h1);
      exp_now("mid_load",   S_LOAD,   16'h0);
      exp_now("mid_exec",   S_EXEC,   16'h0);
      settle();
      #2 reset = 1'b0;
      exp_post("rel2_tgrst", S_RST, 16'h0);
      tick();
      fetch(16'h0020, 16'h1010);
      exp_now("slot_cleared_hold", S_HOLD, 16'h0);
      settle();
      fetch(16'hFFFF, 16'h1011);
      exp_now("disabled_hold", S_HOLD, 16'h0);
      settle();
      exp_post("disabled_status", S_STATUS, 16'h0);
      tick();
      bif.tg_fetch = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
